// File: rtl/ps2kbd_tx.sv
// ps2kbd_tx: PS/2 host-to-keyboard command transmitter (inhibit, request-to-send, 11-bit frame, ack).
// Define PS2TX_ACK_CHECK_EN to turn a high acknowledge bit into a TxError instead of completing.
module ps2kbd_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       KeyClkIn,
    input  logic       KeyDataIn,
    output logic       KeyClkDrive,
    output logic       KeyDataDrive,
    input  logic [7:0] TxData,
    input  logic       TxStart,
    output logic       TxReady,
    output logic       TxDone,
    output logic       TxError,
    output logic       TxActive
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE} stateType;

    stateType state, stateNext;
    logic [1:0] clkSync, dataSync;
    logic clkPrev, keyFall;
    logic [IW-1:0] inhCnt, inhCntNext;
    logic [TW-1:0] toCnt, toCntNext;
    logic [3:0] bitCnt, bitCntNext;
    logic [8:0] txBits, txBitsNext;
    logic clkDriveNext, dataDriveNext, doneNext, errorNext;

    assign keyFall = clkPrev & ~clkSync[1];
    assign TxReady = state == IDLE;
    assign TxActive = state != IDLE;

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            clkSync <= 2'b11;
            dataSync <= 2'b11;
            clkPrev <= 1'b1;
            state <= IDLE;
            inhCnt <= '0;
            toCnt <= '0;
            bitCnt <= '0;
            txBits <= '0;
            KeyClkDrive <= 1'b0;
            KeyDataDrive <= 1'b0;
            TxDone <= 1'b0;
            TxError <= 1'b0;
        end else begin
            clkSync <= {clkSync[0], KeyClkIn};
            dataSync <= {dataSync[0], KeyDataIn};
            clkPrev <= clkSync[1];
            state <= stateNext;
            inhCnt <= inhCntNext;
            toCnt <= toCntNext;
            bitCnt <= bitCntNext;
            txBits <= txBitsNext;
            KeyClkDrive <= clkDriveNext;
            KeyDataDrive <= dataDriveNext;
            TxDone <= doneNext;
            TxError <= errorNext;
        end

    always_comb begin
        stateNext = state;
        inhCntNext = '0;
        toCntNext = '0;
        bitCntNext = bitCnt;
        txBitsNext = txBits;
        doneNext = 1'b0;
        errorNext = 1'b0;
        case (state)
            IDLE: if (TxStart) begin
                txBitsNext = {~^TxData, TxData};
                bitCntNext = '0;
                stateNext = INHIBIT;
            end
            INHIBIT: begin
                inhCntNext = inhCnt + 1'b1;
                if (inhCnt == IW'(INHIBIT_CYCLES - 1)) stateNext = REQ;
            end
            REQ: if (keyFall) begin
                stateNext = DATA;
                bitCntNext = '0;
            end
            // The edge that would present the stop bit enters ACK, whose released line is the stop bit.
            DATA: if (keyFall) begin
                if (bitCnt == 4'd8) stateNext = ACK;
                else bitCntNext = bitCnt + 1'b1;
            end
            ACK: if (keyFall) begin
`ifdef PS2TX_ACK_CHECK_EN
                if (dataSync[1]) begin
                    stateNext = IDLE;
                    errorNext = 1'b1;
                end else stateNext = WAIT_IDLE;
`else
                stateNext = WAIT_IDLE;
`endif
            end
            WAIT_IDLE: if (clkSync[1] && dataSync[1]) begin
                stateNext = IDLE;
                doneNext = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
        if (state inside {REQ, DATA, ACK, WAIT_IDLE}) begin
            toCntNext = toCnt + 1'b1;
            if (toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                stateNext = IDLE;
                errorNext = 1'b1;
                doneNext = 1'b0;
            end
        end
        clkDriveNext = stateNext == INHIBIT;
        dataDriveNext = stateNext == REQ || (stateNext == DATA && !txBitsNext[bitCntNext]);
    end
endmodule

// File: tb/tb_ps2kbd_tx.sv
// tb_ps2kbd_tx: directed + random frames against a PS/2 device model that clocks at 1/40 Clk.
module tb_ps2kbd_tx;
    localparam int INH = 20;
    localparam int TMO = 2000;
    localparam int HALF = 20;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic TxStart = 1'b0;
    logic [7:0] TxData = '0;
    logic devClkLow = 1'b0;
    logic devDataLow = 1'b0;
    logic KeyClkIn, KeyDataIn, KeyClkDrive, KeyDataDrive, TxReady, TxDone, TxError, TxActive;
    int checks = 0;
    int errors = 0;
    int doneCnt = 0;
    int errCnt = 0;
    bit both = 1'b0;

    assign KeyClkIn = ~(KeyClkDrive | devClkLow);
    assign KeyDataIn = ~(KeyDataDrive | devDataLow);

    ps2kbd_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .KeyClkIn(KeyClkIn), .KeyDataIn(KeyDataIn),
        .KeyClkDrive(KeyClkDrive), .KeyDataDrive(KeyDataDrive), .TxData(TxData),
        .TxStart(TxStart), .TxReady(TxReady), .TxDone(TxDone), .TxError(TxError),
        .TxActive(TxActive)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (TxDone) doneCnt++;
        if (TxError) errCnt++;
        if (TxDone && TxError) both = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] d);
        TxData = d;
        TxStart = 1'b1;
        cyc(1);
        TxStart = 1'b0;
        TxData = ~d;
    endtask

    // Counts cycles with the clock line held by the host; returns at the first REQ cycle.
    task automatic measureInhibit(input bit poke, output int n);
        n = 0;
        for (int i = 0; i < INH + 40; i++) begin
            if (KeyClkDrive) n++;
            else if (n > 0) break;
            cyc(1);
            if (poke && n == 5) begin
                TxData = 8'h55;
                TxStart = 1'b1;
            end else TxStart = 1'b0;
        end
        TxStart = 1'b0;
    endtask

    // Device side: nEdges clock pulses, line sampled at each rising edge, ack driven before edge 11.
    task automatic device(input int nEdges, input bit ackLow, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < nEdges; i++) begin
            if (i == 10) begin
                cyc(HALF / 2);
                devDataLow = ackLow;
                cyc(HALF / 2);
            end else cyc(HALF);
            devClkLow = 1'b1;
            cyc(HALF);
            if (i < 10) bits[i] = KeyDataIn;
            devClkLow = 1'b0;
        end
        cyc(2);
        devDataLow = 1'b0;
    endtask

    task automatic waitReady();
        for (int i = 0; i < 60 && !TxReady; i++) cyc(1);
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit ackLow, input bit poke, input string tag);
        int n, d0, e0;
        logic [9:0] bits, expBits;
        logic par;
        bit expDone;
        d0 = doneCnt;
        e0 = errCnt;
        par = ($countones(d) % 2) == 0;
        expBits = {1'b1, par, d};
`ifdef PS2TX_ACK_CHECK_EN
        expDone = ackLow;
`else
        expDone = 1'b1;
`endif
        send(d);
        measureInhibit(poke, n);
        chk({tag, "_inhibit"}, n, INH);
        device(11, ackLow, bits);
        chk({tag, "_bits"}, bits, expBits);
        waitReady();
        chk({tag, "_ready"}, TxReady, 1);
        cyc(3);
        chk({tag, "_done"}, doneCnt - d0, expDone ? 1 : 0);
        chk({tag, "_error"}, errCnt - e0, expDone ? 0 : 1);
        cyc(30);
        chk({tag, "_idle"}, {TxActive, KeyClkDrive, KeyDataDrive}, 0);
    endtask

    initial begin
        int n, k, d0, e0;
        logic [9:0] bits;
        logic [7:0] rnd;
        cyc(3);
        chk("rst_drives", {KeyClkDrive, KeyDataDrive}, 0);
        chk("rst_pulses", {TxDone, TxError}, 0);
        chk("rst_ready_active", {TxReady, TxActive}, 2'b10);
        Reset_n = 1'b1;
        cyc(3);
        chk("post_rst_ready", TxReady, 1);

        sendFrame(8'hED, 1'b1, 1'b0, "ed");
        sendFrame(8'h01, 1'b1, 1'b0, "x01");
        sendFrame(8'hFF, 1'b1, 1'b0, "xff");
        sendFrame(8'h5A, 1'b0, 1'b0, "nack");
        sendFrame(8'hA3, 1'b1, 1'b1, "poke");
        for (int i = 0; i < 4; i++) begin
            rnd = 8'($urandom);
            sendFrame(rnd, 1'b1, 1'b0, "rand");
        end

        d0 = doneCnt;
        e0 = errCnt;
        send(8'hA5);
        measureInhibit(1'b0, n);
        chk("tmo_inhibit", n, INH);
        chk("tmo_req_drive", {KeyClkDrive, KeyDataDrive}, 2'b01);
        k = 0;
        while (!TxError && k < TMO + 100) begin
            cyc(1);
            k++;
        end
        chk("tmo_cycle", k, TMO);
        chk("tmo_drives", {KeyClkDrive, KeyDataDrive}, 0);
        cyc(3);
        chk("tmo_nodone", doneCnt - d0, 0);
        chk("tmo_err", errCnt - e0, 1);

        d0 = doneCnt;
        e0 = errCnt;
        send(8'h3C);
        measureInhibit(1'b0, n);
        device(4, 1'b1, bits);
        chk("abort_bits", bits[3:0], 4'hC);
        Reset_n = 1'b0;
        #1;
        chk("abort_drives", {KeyClkDrive, KeyDataDrive}, 0);
        chk("abort_state", {TxReady, TxActive}, 2'b10);
        cyc(3);
        Reset_n = 1'b1;
        cyc(3);
        chk("abort_pulses", (doneCnt - d0) + (errCnt - e0), 0);
        sendFrame(8'hF4, 1'b1, 1'b0, "f4");

        chk("done_err_same_cycle", both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2kbd_tx.md
PS2KBD_TX -- requirements
Module: ps2kbd_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, number of Clk cycles KeyClk is held low before the request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, maximum Clk cycles from request release to acknowledge (15 ms at 50 MHz).
REQ-003 Clk  in  1  system clock; all state on rising edge.
REQ-004 Reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 KeyClkIn  in  1  raw PS/2 clock line level.
REQ-006 KeyDataIn  in  1  raw PS/2 data line level.
REQ-007 KeyClkDrive  out  1  1 = pull PS/2 clock low (open-drain enable); 0 = release.
REQ-008 KeyDataDrive  out  1  1 = pull PS/2 data low; 0 = release.
REQ-009 TxData  in  8  command byte to send.
REQ-010 TxStart  in  1  request; accepted only in a cycle where TxReady=1.
REQ-011 TxReady  out  1  1 only in IDLE.
REQ-012 TxDone  out  1  one-cycle pulse: byte sent and acknowledged.
REQ-013 TxError  out  1  one-cycle pulse: timeout or missing acknowledge.
REQ-014 TxActive  out  1  1 whenever not IDLE; gates the keyboard receiver.

Function
REQ-015 KeyClkIn and KeyDataIn SHALL pass through 2-flop synchronizers; a falling edge SHALL be a synchronized 1 followed by synchronized 0 on consecutive cycles.
REQ-016 States: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE.
REQ-017 IDLE: both drives 0; on TxStart, latch TxData, compute odd parity (~^TxData), go INHIBIT next cycle.
REQ-018 INHIBIT: KeyClkDrive=1, KeyDataDrive=0 for exactly INHIBIT_CYCLES cycles, then go REQ.
REQ-019 REQ: KeyDataDrive=1 (start bit), KeyClkDrive=0; clear timeout counter; on first falling edge go DATA and present bit 0.
REQ-020 DATA: on each falling edge advance a 4-bit counter and present the next symbol: data bits 0..7 LSB first, then parity, then stop (KeyDataDrive=0); KeyDataDrive SHALL equal the inverse of the bit being sent.
REQ-021 The falling edge after the stop bit is presented SHALL move to ACK; total falling edges from REQ to ACK entry = 10.
REQ-022 ACK: on the next falling edge sample synchronized data; 0 = acknowledged, go WAIT_IDLE; 1 = per REQ-030.
REQ-023 WAIT_IDLE: when synchronized clock and data are both 1, pulse TxDone and go IDLE.
REQ-024 Timeout counter SHALL run in REQ, DATA, ACK and WAIT_IDLE; on reaching TIMEOUT_CYCLES release both drives, pulse TxError, go IDLE, without TxDone.
REQ-025 TxStart outside IDLE SHALL be ignored; TxData changes after acceptance SHALL NOT affect the frame.
REQ-026 TxDone and TxError SHALL never be asserted in the same cycle.
REQ-027 Drive outputs SHALL be registered (glitch-free).

Reset
REQ-028 Reset_n low SHALL immediately force IDLE, KeyClkDrive=0, KeyDataDrive=0, TxDone=0, TxError=0, TxActive=0, counters cleared; TxReady=1 in reset.
REQ-029 Reset mid-frame SHALL abandon the frame with no TxDone/TxError pulse.

Configuration
REQ-030 Macro PS2TX_ACK_CHECK_EN defined: acknowledge bit 1 SHALL pulse TxError and go IDLE; undefined: the acknowledge edge SHALL always go WAIT_IDLE regardless of data level.

Verification (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clocks at 1/40 Clk)
REQ-031 TxData=8'hED, model acks -> clock held low 20 cycles; bits sampled 1,0,1,1,0,1,1,1, parity 1, stop 1; TxDone one pulse; TxReady returns 1.
REQ-032 TxData=8'h01 -> parity bit 0; TxData=8'hFF -> parity bit 1; both acknowledged with TxDone.
REQ-033 Model never clocks after REQ -> TxError at cycle 2000 after REQ entry, both drives 0, no TxDone.
REQ-034 Model leaves data high on ack edge -> with PS2TX_ACK_CHECK_EN TxError pulse; without it TxDone pulse.
REQ-035 Reset_n low after 4th data bit -> drives 0 within the same cycle, no pulses; next TxStart=8'hF4 completes with TxDone.
REQ-036 TxStart pulsed during INHIBIT with TxData=8'h55 -> ignored; only the original byte is transmitted.
